// File: rtl/uart_arb_pkg.sv
// -----------------------------------------------------------------------------
// uart_arb_pkg
// Shared definitions for the UART transmit arbiter:
//   - arb_state_e : arbiter FSM state encoding
//   - DEF_*       : default sizing for requesters, character width, start timeout
//   - id_width()  : width of a requester index (at least one bit)
// -----------------------------------------------------------------------------
package uart_arb_pkg;

    localparam int DEF_NUM_REQ       = 4;
    localparam int DEF_DATA_BITS     = 8;
    localparam int DEF_START_TIMEOUT = 64;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_START     = 2'd1,
        ST_WAIT_DONE = 2'd2
    } arb_state_e;

    function automatic int id_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/uart_tx_arbiter_rr_pick.sv
// -----------------------------------------------------------------------------
// rr_pick
// Combinational round-robin selector: returns the first asserted request at or
// after index Ptr, wrapping modulo NUM_REQ.
// Ports:
//   Req   [NUM_REQ-1:0] in  : request vector
//   Ptr   [ID_W-1:0]    in  : highest-priority index for this pick
//   valid               out : at least one request is asserted
//   index [ID_W-1:0]    out : winning requester index (0 when !valid)
// -----------------------------------------------------------------------------
module rr_pick
    import uart_arb_pkg::*;
#(
    parameter int  NUM_REQ = DEF_NUM_REQ,
    localparam int ID_W    = id_width(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] Req,
    input  logic [ID_W-1:0]    Ptr,
    output logic               valid,
    output logic [ID_W-1:0]    index
);

    int cand;

    always_comb begin
        // NOTE: every output gets a default before the loop so no path leaves
        // a value unassigned, which would otherwise infer a latch.
        valid = 1'b0;
        index = '0;
        cand  = 0;
        // Walk from the farthest offset back to Ptr so the closest asserted
        // request is the last one written and therefore wins.
        for (int off = NUM_REQ - 1; off >= 0; off--) begin
            cand = int'(Ptr) + off;
            if (cand >= NUM_REQ) begin
                cand = cand - NUM_REQ;
            end
            if (Req[cand]) begin
                valid = 1'b1;
                index = ID_W'(cand);
            end
        end
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// -----------------------------------------------------------------------------
// uart_tx_arbiter
// Shares one UART transmitter among NUM_REQ requesters with round-robin
// fairness, drives the UART start handshake and flags start timeouts.
// Ports:
//   Clk            in  : baud-domain clock, posedge
//   Rst            in  : asynchronous active-low reset
//   Req            in  : per-requester request, held until its Grant pulse
//   Req_Data       in  : per-requester character
//   Grant          out : one-hot, one-cycle acceptance pulse
//   Tx_Busy        in  : UART transmitter busy
//   BIST_Busy      in  : UART self-test running, blocks new grants
//   Tx_Data        out : character presented to the UART, held until next grant
//   Transmit_Start out : UART start strobe, held until Tx_Busy is seen
//   Arb_Busy       out : arbiter not in IDLE
//   Cur_Id         out : index of the requester last granted
//   Timeout_Err    out : sticky start-handshake timeout flag
//   Err_Clr        in  : synchronous clear of Timeout_Err
// -----------------------------------------------------------------------------
module uart_tx_arbiter
    import uart_arb_pkg::*;
#(
    parameter int  NUM_REQ       = DEF_NUM_REQ,
    parameter int  DATA_BITS     = DEF_DATA_BITS,
    parameter int  START_TIMEOUT = DEF_START_TIMEOUT,
    localparam int ID_W          = id_width(NUM_REQ)
) (
    input  logic                               Clk,
    input  logic                               Rst,
    input  logic [NUM_REQ-1:0]                 Req,
    input  logic [NUM_REQ-1:0][DATA_BITS-1:0]  Req_Data,
    output logic [NUM_REQ-1:0]                 Grant,
    input  logic                               Tx_Busy,
    input  logic                               BIST_Busy,
    output logic [DATA_BITS-1:0]               Tx_Data,
    output logic                               Transmit_Start,
    output logic                               Arb_Busy,
    output logic [ID_W-1:0]                    Cur_Id,
    output logic                               Timeout_Err,
    input  logic                               Err_Clr
);

    localparam int              CNT_W    = $clog2(START_TIMEOUT + 1);
    localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(START_TIMEOUT - 1);

    arb_state_e       state;
    logic [ID_W-1:0]  ptr;
    logic [CNT_W-1:0] tmo_cnt;
    logic             pick_valid;
    logic [ID_W-1:0]  pick_idx;
    logic [ID_W-1:0]  next_ptr;

    rr_pick #(
        .NUM_REQ (NUM_REQ)
    ) u_rr_pick (
        .Req   (Req),
        .Ptr   (ptr),
        .valid (pick_valid),
        .index (pick_idx)
    );

    always_comb begin
        next_ptr = (pick_idx == ID_W'(NUM_REQ - 1)) ? '0 : pick_idx + ID_W'(1);
    end

    // NOTE: all state and registered outputs use non-blocking assignments so
    // every branch below sees the pre-edge values regardless of statement order.
    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            state          <= ST_IDLE;
            ptr            <= '0;
            tmo_cnt        <= '0;
            Grant          <= '0;
            Tx_Data        <= '0;
            Transmit_Start <= 1'b0;
            Arb_Busy       <= 1'b0;
            Cur_Id         <= '0;
            Timeout_Err    <= 1'b0;
        end else begin
            Grant <= '0;
            // A timeout in the same cycle overrides this clear (later write wins).
            if (Err_Clr) begin
                Timeout_Err <= 1'b0;
            end

            unique case (state)
                ST_IDLE: begin
                    if (pick_valid && !Tx_Busy && !BIST_Busy) begin
                        state          <= ST_START;
                        Tx_Data        <= Req_Data[pick_idx];
                        Grant          <= NUM_REQ'(1) << pick_idx;
                        Cur_Id         <= pick_idx;
                        ptr            <= next_ptr;
                        tmo_cnt        <= '0;
                        Transmit_Start <= 1'b1;
                        Arb_Busy       <= 1'b1;
                    end
                end

                ST_START: begin
                    if (Tx_Busy) begin
                        state          <= ST_WAIT_DONE;
                        Transmit_Start <= 1'b0;
                    end else if (tmo_cnt == TMO_LAST) begin
                        // UART never answered: drop the character, no retry.
                        state          <= ST_IDLE;
                        Transmit_Start <= 1'b0;
                        Arb_Busy       <= 1'b0;
                        Timeout_Err    <= 1'b1;
                    end else begin
                        tmo_cnt <= tmo_cnt + CNT_W'(1);
                    end
                end

                ST_WAIT_DONE: begin
                    if (!Tx_Busy) begin
                        state    <= ST_IDLE;
                        Arb_Busy <= 1'b0;
                    end
                end

                default: begin
                    state          <= ST_IDLE;
                    Transmit_Start <= 1'b0;
                    Arb_Busy       <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// -----------------------------------------------------------------------------
// tb_uart_tx_arbiter
// Scoreboard bench: a transaction-level reference model predicts grants from
// the inputs seen at each rising edge and queues them; a negedge monitor pops
// and compares against what the arbiter presents. A behavioural UART drives
// Tx_Busy in response to Transmit_Start.
// -----------------------------------------------------------------------------
module tb_uart_tx_arbiter;

    localparam int N    = 4;
    localparam int DW   = 8;
    localparam int TMO  = 64;
    localparam int IDW  = 2;

    logic                  Clk = 1'b0;
    logic                  Rst;
    logic [N-1:0]          Req;
    logic [N-1:0][DW-1:0]  Req_Data;
    logic [N-1:0]          Grant;
    logic                  Tx_Busy;
    logic                  BIST_Busy;
    logic [DW-1:0]         Tx_Data;
    logic                  Transmit_Start;
    logic                  Arb_Busy;
    logic [IDW-1:0]        Cur_Id;
    logic                  Timeout_Err;
    logic                  Err_Clr;

    uart_tx_arbiter #(
        .NUM_REQ       (N),
        .DATA_BITS     (DW),
        .START_TIMEOUT (TMO)
    ) dut (
        .Clk            (Clk),
        .Rst            (Rst),
        .Req            (Req),
        .Req_Data       (Req_Data),
        .Grant          (Grant),
        .Tx_Busy        (Tx_Busy),
        .BIST_Busy      (BIST_Busy),
        .Tx_Data        (Tx_Data),
        .Transmit_Start (Transmit_Start),
        .Arb_Busy       (Arb_Busy),
        .Cur_Id         (Cur_Id),
        .Timeout_Err    (Timeout_Err),
        .Err_Clr        (Err_Clr)
    );

    always #5 Clk = ~Clk;

    int errors = 0;
    int checks = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model (transfer lifecycle) ----------------
    typedef struct {
        int          cyc;
        int          id;
        logic [DW-1:0] data;
    } exp_t;

    exp_t exp_q[$];
    int   grant_log[$];

    localparam int M_FREE     = 0;  // no transfer in flight
    localparam int M_STARTING = 1;  // waiting for the UART to accept
    localparam int M_SENDING  = 2;  // UART busy with our character

    int            cyc     = 0;
    int            m_state = M_FREE;
    int            m_ptr   = 0;
    int            m_age   = 0;
    int            m_id    = 0;
    logic [DW-1:0] m_data  = '0;
    bit            m_err   = 1'b0;

    function automatic int rr_first(input logic [N-1:0] r, input int p);
        for (int k = 0; k < N; k++) begin
            if (r[(p + k) % N]) return (p + k) % N;
        end
        return -1;
    endfunction

    initial begin
        exp_t e;
        int   w;
        bit   new_err;
        forever begin
            @(posedge Clk);
            cyc++;
            if (!Rst) begin
                m_state = M_FREE;
                m_ptr   = 0;
                m_age   = 0;
                m_id    = 0;
                m_data  = '0;
                m_err   = 1'b0;
                exp_q.delete();
            end else begin
                new_err = 1'b0;
                case (m_state)
                    M_FREE: begin
                        if (Req != '0 && !Tx_Busy && !BIST_Busy) begin
                            w      = rr_first(Req, m_ptr);
                            e.cyc  = cyc;
                            e.id   = w;
                            e.data = Req_Data[w];
                            exp_q.push_back(e);
                            m_ptr   = (w + 1) % N;
                            m_id    = w;
                            m_data  = Req_Data[w];
                            m_age   = 0;
                            m_state = M_STARTING;
                        end
                    end
                    M_STARTING: begin
                        if (Tx_Busy) begin
                            m_state = M_SENDING;
                        end else begin
                            m_age++;
                            if (m_age >= TMO) begin
                                new_err = 1'b1;
                                m_state = M_FREE;
                            end
                        end
                    end
                    default: begin
                        if (!Tx_Busy) m_state = M_FREE;
                    end
                endcase
                if (new_err) m_err = 1'b1;
                else if (Err_Clr) m_err = 1'b0;
            end
        end
    end

    // ---------------- monitor ----------------
    initial begin
        exp_t e;
        forever begin
            @(negedge Clk);
            check("grant_onehot", 64'($onehot0(Grant)), 64'd1);
            if (exp_q.size() > 0 && exp_q[0].cyc == cyc) begin
                e = exp_q.pop_front();
                check("grant_vec", Grant, N'(1) << e.id);
                check("grant_data", Tx_Data, e.data);
            end else begin
                check("grant_none", Grant, '0);
            end
            for (int i = 0; i < N; i++) begin
                if (Grant[i]) grant_log.push_back(i);
            end
            check("tx_data_hold", Tx_Data, m_data);
            check("cur_id", Cur_Id, m_id);
            check("transmit_start", Transmit_Start, m_state == M_STARTING);
            check("arb_busy", Arb_Busy, m_state != M_FREE);
            check("timeout_err", Timeout_Err, m_err);
        end
    end

    // ---------------- behavioural UART ----------------
    int ign_mode = 2;   // 0: random ignore + spontaneous busy, 1: always ignore, 2: always answer
    int busy_min = 1;
    int busy_max = 6;

    initial begin
        Tx_Busy = 1'b0;
        forever begin
            @(negedge Clk);
            if (Rst && Transmit_Start) begin
                if (ign_mode == 1 || (ign_mode == 0 && $urandom_range(7) == 0)) begin
                    for (int k = 0; k < 200 && Transmit_Start; k++) @(negedge Clk);
                end else begin
                    repeat ($urandom_range(3)) @(negedge Clk);
                    Tx_Busy = 1'b1;
                    repeat ($urandom_range(busy_max, busy_min)) @(negedge Clk);
                    Tx_Busy = 1'b0;
                end
            end else if (ign_mode == 0 && Rst && $urandom_range(15) == 0) begin
                Tx_Busy = 1'b1;
                repeat ($urandom_range(3, 1)) @(negedge Clk);
                Tx_Busy = 1'b0;
            end
        end
    end

    // ---------------- requester stimulus ----------------
    int req_mode = 2;   // 0: random, 1: sticky, 2: drop on grant only

    task automatic tick();
        @(negedge Clk);
        #1;
        for (int i = 0; i < N; i++) begin
            if (req_mode != 1 && Grant[i]) begin
                Req[i] = 1'b0;
            end else if (req_mode == 0) begin
                if (!Req[i] && $urandom_range(3) == 0) begin
                    Req[i]      = 1'b1;
                    Req_Data[i] = DW'($urandom);
                end else if (Req[i] && $urandom_range(63) == 0) begin
                    Req[i] = 1'b0;
                end
            end
        end
    endtask

    task automatic drain(input int n);
        Req       = '0;
        BIST_Busy = 1'b0;
        Err_Clr   = 1'b0;
        req_mode  = 2;
        repeat (n) tick();
    endtask

    initial begin
        int n0;
        int bist_left;
        Rst       = 1'b0;
        Req       = '0;
        Req_Data  = '0;
        BIST_Busy = 1'b0;
        Err_Clr   = 1'b0;

        // Async reset state before any clock edge
        #3;
        check("rst_grant", Grant, '0);
        check("rst_start", Transmit_Start, 1'b0);
        check("rst_data", Tx_Data, '0);
        check("rst_busy", Arb_Busy, 1'b0);
        check("rst_id", Cur_Id, '0);
        check("rst_err", Timeout_Err, 1'b0);
        repeat (3) tick();
        Rst = 1'b1;
        tick();

        // Four continuous requesters from Ptr=0: order 0,1,2,3,0
        grant_log.delete();
        req_mode = 1;
        Req      = 4'b1111;
        for (int i = 0; i < N; i++) Req_Data[i] = DW'(8'h10 + i);
        for (int k = 0; k < 300 && grant_log.size() < 5; k++) tick();
        check("rr_count", grant_log.size() >= 5, 1'b1);
        for (int i = 0; i < 5 && i < grant_log.size(); i++) begin
            check("rr_order", grant_log[i], i % N);
        end
        drain(40);

        // Single request, character A5
        grant_log.delete();
        Req_Data[2] = 8'hA5;
        Req         = 4'b0100;
        for (int k = 0; k < 30 && grant_log.size() < 1; k++) tick();
        check("single_id", grant_log.size() > 0 ? grant_log[0] : -1, 2);
        tick();
        check("single_data", Tx_Data, 8'hA5);
        drain(20);

        // BIST blocks grants in IDLE; release grants on next edge
        grant_log.delete();
        BIST_Busy = 1'b1;
        req_mode  = 1;
        Req       = 4'b1111;
        repeat (20) tick();
        check("bist_nogrant", grant_log.size(), 0);
        BIST_Busy = 1'b0;
        tick();
        tick();
        check("bist_release", grant_log.size(), 1);
        drain(40);

        // Start timeout: UART never answers
        ign_mode = 1;
        grant_log.delete();
        Req_Data[0] = 8'h3C;
        Req         = 4'b0001;
        repeat (TMO + 10) tick();
        check("tmo_err", Timeout_Err, 1'b1);
        check("tmo_idle", Arb_Busy, 1'b0);
        check("tmo_one_grant", grant_log.size(), 1);
        Err_Clr = 1'b1;
        tick();
        Err_Clr = 1'b0;
        tick();
        check("tmo_clr", Timeout_Err, 1'b0);
        ign_mode = 2;
        drain(10);

        // Reset during WAIT_DONE, then restart from Ptr=0
        busy_min = 8;
        busy_max = 8;
        Req      = 4'b1000;
        n0       = 0;
        while (n0 < 50 && !(Arb_Busy && !Transmit_Start && Tx_Busy)) begin
            tick();
            n0++;
        end
        check("wait_done_reached", n0 < 50, 1'b1);
        #2 Rst = 1'b0;
        #1;
        check("arst_grant", Grant, '0);
        check("arst_start", Transmit_Start, 1'b0);
        check("arst_data", Tx_Data, '0);
        check("arst_busy", Arb_Busy, 1'b0);
        check("arst_id", Cur_Id, '0);
        Req = '0;
        repeat (12) tick();
        busy_min = 1;
        busy_max = 6;
        grant_log.delete();
        Req = 4'b0010;
        Rst = 1'b1;
        for (int k = 0; k < 20 && grant_log.size() < 1; k++) tick();
        check("post_rst_id", grant_log.size() > 0 ? grant_log[0] : -1, 1);
        drain(20);

        // Randomised traffic with BIST windows, Err_Clr pulses, UART stalls
        ign_mode  = 0;
        req_mode  = 0;
        bist_left = 0;
        for (int c = 0; c < 6000; c++) begin
            tick();
            if (bist_left > 0) begin
                bist_left--;
            end else begin
                BIST_Busy = 1'b0;
                if ($urandom_range(49) == 0) begin
                    BIST_Busy = 1'b1;
                    bist_left = $urandom_range(20, 1);
                end
            end
            Err_Clr = ($urandom_range(39) == 0);
        end
        ign_mode = 2;
        drain(150);
        check("queue_empty", exp_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
